// File: rtl/enc_pkg.sv
// Shared types and constants for the field-level RV instruction encoder.
// Latency: n/a (types, constants and one pure decode function).
// Backpressure: n/a.
package enc_pkg;

  // Major opcodes the encoder knows how to pack
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1b;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_REG32  = 7'h3b;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6f;

  // First-error codes reported on err_code
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_RANGE  = 2'd2;
  localparam logic [1:0] ERR_WRAP   = 2'd3;

  typedef enum logic [2:0] {
    FMT_I, FMT_SH, FMT_R, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_t;

  // One decoded field tuple as held in the first pipeline stage
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // Instruction format implied by opcode (and funct3 for the shift-immediates)
  function automatic fmt_t fmt_of(input logic [6:0] op, input logic [2:0] f3);
    fmt_t f;
    f = FMT_BAD;
    case (op)
      OP_IMM, OP_IMM32:  f = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
      OP_LOAD, OP_JALR:  f = FMT_I;
      OP_REG, OP_REG32:  f = FMT_R;
      OP_STORE:          f = FMT_S;
      OP_BRANCH:         f = FMT_B;
      OP_AUIPC, OP_LUI:  f = FMT_U;
      OP_JAL:            f = FMT_J;
      default:           f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs a field tuple into a 32-bit RV word for a given format; flags out-of-range immediates.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on whatever S1 holds. Range check only with ENC_RANGE_CHECK_EN.
module instr_pack
  import enc_pkg::*;
(
  input  fields_t     f,
  input  fmt_t        fmt,
  output logic [31:0] word,
  output logic        range_fail
);

  // Scatter the fields into the bit positions of the selected format
  always_comb begin
    word = 32'h0;
    case (fmt)
      FMT_I:  word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_SH: word = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_R:  word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S:  word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B:  word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                      f.imm[4:1], f.imm[11], f.opcode};
      FMT_U:  word = {f.imm[31:12], f.rd, f.opcode};
      FMT_J:  word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: word = 32'h0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Immediate must be representable by the format's encoded bits
  always_comb begin
    range_fail = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_fail = (f.imm[31:11] != {21{f.imm[11]}});
      FMT_B:        range_fail = (f.imm[31:12] != {20{f.imm[12]}}) | f.imm[0];
      FMT_J:        range_fail = (f.imm[31:20] != {12{f.imm[20]}}) | f.imm[0];
      FMT_U:        range_fail = (f.imm[11:0] != 12'h0);
      FMT_SH:       range_fail = (f.imm[11:5] != 7'h0);
      default:      range_fail = 1'b0;
    endcase
  end
`else
  // Without the check, bits outside the format are silently dropped
  assign range_fail = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Field-tuple to RV instruction encoder writing packed words to imem at an auto-incrementing address.
// Latency: tuple accepted at edge N -> mem_we with the word after edge N+1; one word/cycle while mem_ready.
// Backpressure: in_ready = !s1_valid | s2_free (combinational from mem_ready); S2 holds steady while stalled.
// Optional immediate range check enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy
);

  fields_t     in_fields;
  fields_t     s1_q;
  logic        s1_valid;
  logic        s2_valid;
  fmt_t        s1_fmt;
  logic [31:0] pack_word;
  logic        pack_fail;
  logic        s1_bad;
  logic        s2_free;
  logic        s1_adv;
  logic        accept;
  logic        complete;
  logic        wrapped_q;
  logic        err_set;
  logic [1:0]  err_new;

  assign in_fields = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                       funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  assign complete = s2_valid & mem_ready;
  assign s2_free  = ~s2_valid | mem_ready;
  assign s1_adv   = s1_valid & s2_free;
  assign in_ready = ~s1_valid | s2_free;
  assign accept   = in_valid & in_ready;

  assign s1_fmt = fmt_of(s1_q.opcode, s1_q.funct3);
  assign s1_bad = (s1_fmt == FMT_BAD) | pack_fail;

  assign mem_we = s2_valid;
  assign busy   = s1_valid | s2_valid;

  instr_pack u_pack (
    .f          (s1_q),
    .fmt        (s1_fmt),
    .word       (pack_word),
    .range_fail (pack_fail)
  );

  // S1: capture accepted tuple; empties when it moves on (or is dropped)
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= in_fields;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: holds the encoded word until imem takes it; bad tuples never land here
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      mem_wdata <= 32'h0;
    end else if (s1_adv && !s1_bad) begin
      s2_valid  <= 1'b1;
      mem_wdata <= pack_word;
    end else if (complete) begin
      s2_valid  <= 1'b0;
    end
  end

  // Write address, saturating write count and the has-wrapped marker
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= ADDR_W'(BASE_ADDR);
      count     <= '0;
      wrapped_q <= 1'b0;
    end else if (complete) begin
      mem_addr <= mem_addr + 1'b1;
      if (mem_addr == '1) wrapped_q <= 1'b1;
      if (count != '1) count <= count + 1'b1;
    end
  end

  // Pick this cycle's error; a write landing past the wrap is older than S1's tuple
  always_comb begin
    err_set = 1'b0;
    err_new = ERR_NONE;
    if (complete && wrapped_q) begin
      err_set = 1'b1;
      err_new = ERR_WRAP;
    end else if (s1_adv && s1_bad) begin
      err_set = 1'b1;
      err_new = (s1_fmt == FMT_BAD) ? ERR_OPCODE : ERR_RANGE;
    end
  end

  // Sticky error flag; only the first code is kept until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (err_set) begin
      err <= 1'b1;
      if (err_code == ERR_NONE) err_code <= err_new;
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV instruction encoder: the inverse of the control decoder. It accepts decoded field tuples (opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake and packs each into a 32-bit instruction word in the format implied by the opcode. Each word is written to instruction memory at an auto-incrementing word address. It sits between the test/boot loader and imem, so programs can be built from field-level descriptions.

## Interface
Parameters:
- ADDR_W, 10: word-address width of imem.
- BASE_ADDR, 0: first write address after reset.

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder can accept; transfer happens when in_valid & in_ready.
- in_opcode  in  7  opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3 / in_funct7  in  7  function fields.
- in_imm  in  32  immediate in its architectural (unscrambled, sign-extended) value.
- mem_we  out  1  write request to imem.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  imem accepts the write when mem_we & mem_ready.
- count  out  ADDR_W+1  words written since reset; saturates at all-ones.
- err  out  1  sticky error flag.
- err_code  out  2  first error: 0 none, 1 bad opcode, 2 immediate out of range, 3 address wrap.
- busy  out  1  any pipeline stage valid.

## Operation
- Two-stage pipeline:
  - S1 registers the accepted fields.
  - S2 holds the encoded word and drives mem_we.
- Format by opcode:
  - I, for 0x03, 0x13, 0x1b, 0x67: {imm[11:0],rs1,f3,rd,op}.
  - Shift-immediate, for 0x13/0x1b with f3 = 001 or 101: {funct7,imm[4:0],rs1,f3,rd,op}.
  - R, for 0x33, 0x3b: {f7,rs2,rs1,f3,rd,op}.
  - S, for 0x23: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - B, for 0x63: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - U, for 0x17, 0x37: {imm[31:12],rd,op}.
  - J, for 0x6f: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Unsupported opcode: the tuple is dropped in S1 and never reaches S2. err is set; err_code = 1 if err_code was 0.
- Address counter starts at BASE_ADDR and increments on each completed write (mem_we & mem_ready).
  - Wraps from 2^ADDR_W-1 to 0.
  - The wrapping write is still performed, and it sets err with code 3 (first-error rule).
- err and err_code clear only on rst. Later errors do not overwrite err_code.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, err=0, err_code=0, busy=0. Both stage valids are cleared.
- Latency: tuple accepted at edge N → mem_we=1 with the word visible after edge N+1.
- Throughput: one word per cycle while mem_ready=1.
- S2 is free when it is empty or completing this cycle. S1 advances when it is valid and S2 is free.
- in_ready = !s1_valid | s2_free. It is combinational from mem_ready.
- mem_we, mem_addr and mem_wdata stay stable while mem_we=1 and mem_ready=0.
- Simultaneous accept and complete: both occur in the same cycle; no bubble.
- rst mid-operation: in-flight tuples are discarded and no further write is issued. A write that is handshaking on the reset edge is not counted.

## Configuration
- ENC_RANGE_CHECK_EN defined: the immediate is checked in S1. A failing tuple is dropped, with err_code 2. The immediate fails if:
  - I/S: it is not the sign extension of 12 bits.
  - B: it is not 13-bit sign-extended, or imm[0]≠0.
  - J: it is not 21-bit sign-extended, or imm[0]≠0.
  - U: imm[11:0]≠0.
  - Shift-immediate: imm[11:5]≠0.
- Not defined: no check is made. Immediate bits outside the format are silently discarded, and the word is written.

## Structure
- Package enc_pkg holds:
  - opcode localparams (OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_REG, OP_REG32, OP_STORE, OP_BRANCH, OP_AUIPC, OP_LUI, OP_JAL);
  - a format enum (FMT_I, FMT_SH, FMT_R, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD);
  - err_code localparams.
- One combinational sub-module, instr_pack: fields + format → 32-bit word and range-fail flag. It is instantiated between S1 and S2.

## Test plan
- addi x1,x0,5 (op 0x13, rd 1, imm 5) with mem_ready=1 → mem_wdata 0x00500093 at addr 0, mem_we exactly 2 edges after accept; count=1.
- Back-to-back lui x2,0x12345000; beq x1,x2,-8; jal x1,+2048 → words 0x12345137, 0xFE208CE3, 0x001000EF at addrs 0,1,2 on consecutive cycles.
- 4 tuples streamed with mem_ready held low for 3 cycles → in_ready drops after 2 accepts; mem_wdata held stable; all 4 words written in order, none lost.
- Opcode 0x7F, then a valid addi → no write for 0x7F; err=1, err_code=1; the addi lands at addr 0.
- ENC_RANGE_CHECK_EN defined, addi imm=4096 → dropped, err_code=2. Not defined → word 0x00000093 written.
- ADDR_W=2, 5 writes, then rst asserted while S1 and S2 are both full:
  - the 5th write wraps to addr 0 and sets err_code=3;
  - after reset, mem_we=0, count=0 and no stale write appears.
